// File: rtl/mul_harness_pkg.sv
// Shared types and constants for the multiplier stress harness.
package mul_harness_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_CHECK  = 3'd3,
    S_FINISH = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam int unsigned XS_SH_A = 13;
  localparam int unsigned XS_SH_B = 7;
  localparam int unsigned XS_SH_C = 17;

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/harness_xorshift.sv
// WIDTH-bit xorshift operand generator; exposes the next two values so a
// vector's a/b pair can be registered in a single cycle.
module harness_xorshift
  import mul_harness_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter logic [WIDTH-1:0] SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             adv,
  output logic [WIDTH-1:0] x1,
  output logic [WIDTH-1:0] x2
);

  // An all-zero state would lock the generator at zero forever.
  localparam logic [WIDTH-1:0] SEED_EFF =
    (SEED == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;

  function automatic logic [WIDTH-1:0] xs_step(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] y;
    y = x ^ (x << XS_SH_A);
    y = y ^ (y >> XS_SH_B);
    y = y ^ (y << XS_SH_C);
    return y;
  endfunction

  logic [WIDTH-1:0] x_r;

  assign x1 = xs_step(x_r);
  assign x2 = xs_step(x1);

  // Generator state: reload on reset or run start, advance two steps per vector.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      x_r <= SEED_EFF;
    end else if (adv) begin
      x_r <= x2;
    end else begin
      x_r <= x_r;
    end
  end

endmodule

// File: rtl/mul_stress_harness.sv
// Drives NUM_VECTORS operand pairs through the multiplier handshake, checks
// each product against a golden multiply and folds products into a signature.
module mul_stress_harness
  import mul_harness_pkg::*;
#(
  parameter int WIDTH          = 128,
  parameter int NUM_VECTORS    = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CHECK_MODE     = 1,
  parameter logic [WIDTH-1:0] SEED = {{(WIDTH-1){1'b0}}, 1'b1},
  localparam int CW = count_width(NUM_VECTORS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_enable,
  input  logic [2*WIDTH-1:0] mul_ab,
  input  logic               mul_done,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic [CW-1:0]      vec_count,
  output logic [CW-1:0]      err_count,
  output logic [2*WIDTH-1:0] signature
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_VEC = CW'(NUM_VECTORS - 1);
  localparam logic [CW-1:0] ERR_MAX  = CW'(NUM_VECTORS);
  localparam logic [TW-1:0] TIMER_HIT = TW'(TIMEOUT_CYCLES);

  state_t             state_r;
  state_t             state_s;
  logic [TW-1:0]      timer_r;
  logic [2*WIDTH-1:0] product_r;
  logic [2*WIDTH-1:0] golden_s;
  logic [WIDTH-1:0]   x1_s;
  logic [WIDTH-1:0]   x2_s;
  logic               start_ok_s;
  logic               gen_adv_s;
  logic               timer_hit_s;

  assign start_ok_s  = start && ((state_r == S_IDLE) || (state_r == S_DONE));
  assign gen_adv_s   = (state_r == S_LOAD) && (vec_count != {CW{1'b0}});
  assign timer_hit_s = (timer_r == TIMER_HIT);
  assign golden_s    = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};

  harness_xorshift #(
    .WIDTH(WIDTH),
    .SEED (SEED)
  ) u_gen (
    .clk (clk),
    .rst (rst),
    .load(start_ok_s),
    .adv (gen_adv_s),
    .x1  (x1_s),
    .x2  (x2_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic; timeout is evaluated ahead of mul_done.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) state_s = S_LOAD;
        else       state_s = state_r;
      end
      S_LOAD: state_s = S_RUN;
      S_RUN: begin
        if (timer_hit_s)   state_s = S_FINISH;
        else if (mul_done) state_s = S_CHECK;
        else               state_s = S_RUN;
      end
      S_CHECK: begin
        if (vec_count == LAST_VEC) state_s = S_FINISH;
        else                       state_s = S_LOAD;
      end
      S_FINISH: state_s = S_DONE;
      default:  state_s = S_IDLE;
    endcase
  end

  // Datapath, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a      <= {WIDTH{1'b0}};
      mul_b      <= {WIDTH{1'b0}};
      mul_enable <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      vec_count  <= {CW{1'b0}};
      err_count  <= {CW{1'b0}};
      signature  <= {(2*WIDTH){1'b0}};
      product_r  <= {(2*WIDTH){1'b0}};
      timer_r    <= {TW{1'b0}};
    end else begin
      mul_enable <= (state_s == S_RUN);
      busy       <= (state_s == S_LOAD) || (state_s == S_RUN) ||
                    (state_s == S_CHECK) || (state_s == S_FINISH);
      done       <= (state_s == S_DONE);
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            pass      <= 1'b0;
            timeout   <= 1'b0;
            vec_count <= {CW{1'b0}};
            err_count <= {CW{1'b0}};
            signature <= {(2*WIDTH){1'b0}};
          end
        end
        S_LOAD: begin
          timer_r <= {TW{1'b0}};
          // Vector 0 is the all-ones corner case.
          if (vec_count == {CW{1'b0}}) begin
            mul_a <= {WIDTH{1'b1}};
            mul_b <= {WIDTH{1'b1}};
          end else begin
            mul_a <= x1_s;
            mul_b <= x2_s;
          end
        end
        S_RUN: begin
          if (timer_hit_s) begin
            timeout <= 1'b1;
          end else begin
            timer_r <= timer_r + TW'(1);
            if (mul_done) product_r <= mul_ab;
          end
        end
        S_CHECK: begin
          signature <= {signature[2*WIDTH-2:0], signature[2*WIDTH-1]} ^ product_r;
          vec_count <= vec_count + CW'(1);
          if ((CHECK_MODE != 0) && (product_r != golden_s) && (err_count != ERR_MAX))
            err_count <= err_count + CW'(1);
        end
        S_FINISH: pass <= (err_count == {CW{1'b0}}) && !timeout;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_stress_harness.sv
// Directed bench: three harness instances (SEED=1, SEED=0, CHECK_MODE=0) share
// one behavioural latency-3 multiplier driven by the first instance.
module tb_mul_stress_harness;

  localparam int W   = 32;
  localparam int NV  = 4;
  localparam int TO  = 20;
  localparam int LAT = 3;
  localparam int CW  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic poke = 1'b0;
  logic mul_done_m = 1'b0;
  logic mul_done;
  logic [2*W-1:0] mul_ab = '0;

  logic [W-1:0]   mul_a0, mul_b0, mul_a1, mul_b1, mul_a2, mul_b2;
  logic           en0, en1, en2, busy0, busy1, busy2, done0, done1, done2;
  logic           pass0, pass1, pass2, to0, to1, to2;
  logic [CW-1:0]  vec0, vec1, vec2, err0, err1, err2;
  logic [2*W-1:0] sig0, sig1, sig2;

  int n_run = 0;
  int n_fail = 0;
  int fault_vec = -1;
  bit never_done = 1'b0;
  int lat_cnt = 0;
  int vidx = 0;

  logic [W-1:0] va [NV];
  logic [W-1:0] vb [NV];
  logic [W-1:0] a_seen [NV];
  logic [W-1:0] b_seen [NV];
  logic [2*W-1:0] sig_v0;
  logic [2*W-1:0] exp1, exp2;

  always #5 clk = ~clk;

  assign mul_done = mul_done_m | poke;

  mul_stress_harness #(.WIDTH(W), .NUM_VECTORS(NV), .TIMEOUT_CYCLES(TO), .CHECK_MODE(1), .SEED(32'h1)) dut0 (
    .clk(clk), .rst(rst), .start(start), .mul_a(mul_a0), .mul_b(mul_b0), .mul_enable(en0),
    .mul_ab(mul_ab), .mul_done(mul_done), .busy(busy0), .done(done0), .pass(pass0),
    .timeout(to0), .vec_count(vec0), .err_count(err0), .signature(sig0));

  mul_stress_harness #(.WIDTH(W), .NUM_VECTORS(NV), .TIMEOUT_CYCLES(TO), .CHECK_MODE(1), .SEED(32'h0)) dut1 (
    .clk(clk), .rst(rst), .start(start), .mul_a(mul_a1), .mul_b(mul_b1), .mul_enable(en1),
    .mul_ab(mul_ab), .mul_done(mul_done), .busy(busy1), .done(done1), .pass(pass1),
    .timeout(to1), .vec_count(vec1), .err_count(err1), .signature(sig1));

  mul_stress_harness #(.WIDTH(W), .NUM_VECTORS(NV), .TIMEOUT_CYCLES(TO), .CHECK_MODE(0), .SEED(32'h1)) dut2 (
    .clk(clk), .rst(rst), .start(start), .mul_a(mul_a2), .mul_b(mul_b2), .mul_enable(en2),
    .mul_ab(mul_ab), .mul_done(mul_done), .busy(busy2), .done(done2), .pass(pass2),
    .timeout(to2), .vec_count(vec2), .err_count(err2), .signature(sig2));

  // Behavioural multiplier: mul_done during the third cycle of mul_enable.
  always @(posedge clk) begin
    if (rst || (start && !busy0)) vidx <= 0;
    else if (en0 && mul_done_m) vidx <= vidx + 1;
    if (!en0 || mul_done_m) begin
      lat_cnt    <= 0;
      mul_done_m <= 1'b0;
    end else begin
      lat_cnt <= lat_cnt + 1;
      if (lat_cnt == LAT - 2 && !never_done) begin
        mul_done_m <= 1'b1;
        mul_ab <= ({32'h0, mul_a0} * {32'h0, mul_b0}) ^ ((vidx == fault_vec) ? 64'h1 : 64'h0);
      end
    end
  end

  function automatic logic [W-1:0] xs(input logic [W-1:0] x);
    logic [W-1:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  function automatic logic [2*W-1:0] exp_sig(input int fv);
    logic [2*W-1:0] s, p;
    s = '0;
    for (int i = 0; i < NV; i++) begin
      p = {32'h0, va[i]} * {32'h0, vb[i]};
      if (i == fv) p = p ^ 64'h1;
      s = {s[2*W-2:0], s[2*W-1]} ^ p;
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, then follow the run to done (bounded), recording handshake timing.
  task automatic run(input bit noisy, output int n, output int en_first, output int en_cnt);
    int k;
    bit prev_en, got_v0;
    n = 0; en_first = -1; en_cnt = 0; k = 0; prev_en = 1'b0; got_v0 = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!done0 && n < 200) begin
      tick();
      n++;
      start = noisy && (n == 6 || n == 13);
      if (en0) begin
        en_cnt++;
        if (en_first < 0) en_first = n;
        if (!prev_en && k < NV) begin
          a_seen[k] = mul_a0;
          b_seen[k] = mul_b0;
          k++;
        end
      end
      prev_en = en0;
      if (vec0 == 3'd1 && !got_v0) begin
        sig_v0 = sig0;
        got_v0 = 1'b1;
      end
    end
    start = 1'b0;
    check("run_reaches_done", {63'h0, done0}, 64'h1);
  endtask

  initial begin
    int n, ef, ec;
    #200000;
    $display("FAIL global_time_limit: got no finish, want finish");
    $fatal(1, "time limit");
  end

  initial begin
    int n, ef, ec, w;
    va[0] = 32'hFFFFFFFF;
    vb[0] = 32'hFFFFFFFF;
    begin
      logic [W-1:0] x;
      x = 32'h1;
      for (int i = 1; i < NV; i++) begin
        x = xs(x); va[i] = x;
        x = xs(x); vb[i] = x;
      end
    end
    exp1 = exp_sig(-1);
    exp2 = exp_sig(2);

    // Reset state
    repeat (3) tick();
    check("rst_busy", {63'h0, busy0}, 64'h0);
    check("rst_enable", {63'h0, en0}, 64'h0);
    check("rst_sig", sig0, 64'h0);
    rst = 1'b0;
    tick();
    check("idle_done", {63'h0, done0}, 64'h0);
    check("idle_vec", {61'h0, vec0}, 64'h0);

    // mul_done pulses in IDLE are ignored
    poke = 1'b1; tick(); tick(); poke = 1'b0; tick();
    check("idle_poke_vec", {61'h0, vec0}, 64'h0);
    check("idle_poke_busy", {63'h0, busy0}, 64'h0);
    check("idle_poke_sig", sig0, 64'h0);

    // Scenario 1: correct multiplier
    run(1'b0, n, ef, ec);
    check("s1_cycles", 64'(n), 64'd22);
    check("s1_enable_latency", 64'(ef), 64'd2);
    check("s1_enable_cycles", 64'(ec), 64'd12);
    check("s1_v0_product", sig_v0, 64'hFFFFFFFE00000001);
    check("s1_v1_a_hand", {32'h0, a_seen[1]}, 64'h40822041);
    for (int i = 0; i < NV; i++) begin
      check($sformatf("s1_a%0d", i), {32'h0, a_seen[i]}, {32'h0, va[i]});
      check($sformatf("s1_b%0d", i), {32'h0, b_seen[i]}, {32'h0, vb[i]});
    end
    check("s1_pass", {63'h0, pass0}, 64'h1);
    check("s1_err", {61'h0, err0}, 64'h0);
    check("s1_vec", {61'h0, vec0}, 64'd4);
    check("s1_sig", sig0, exp1);
    check("s1_busy", {63'h0, busy0}, 64'h0);
    check("s1_timeout", {63'h0, to0}, 64'h0);
    check("s1_enable_low", {63'h0, en0}, 64'h0);
    check("s1_seed0_sig", sig1, exp1);
    check("s1_seed0_pass", {63'h0, pass1}, 64'h1);
    check("s1_nochk_sig", sig2, exp1);

    // Scenario 2: product of vector 2 corrupted
    fault_vec = 2;
    run(1'b0, n, ef, ec);
    fault_vec = -1;
    check("s2_err", {61'h0, err0}, 64'h1);
    check("s2_pass", {63'h0, pass0}, 64'h0);
    check("s2_vec", {61'h0, vec0}, 64'd4);
    check("s2_done", {63'h0, done0}, 64'h1);
    check("s2_sig", sig0, exp2);
    check("s2_seed0_err", {61'h0, err1}, 64'h1);
    // Scenario 6: signature-only instance ignores the mismatch
    check("s6_err", {61'h0, err2}, 64'h0);
    check("s6_pass", {63'h0, pass2}, 64'h1);
    check("s6_sig", sig2, exp2);
    check("s6_sig_differs", {63'h0, (sig2 != exp1)}, 64'h1);

    // Scenario 3: multiplier never answers
    never_done = 1'b1;
    run(1'b0, n, ef, ec);
    never_done = 1'b0;
    check("s3_cycles", 64'(n), 64'd24);
    check("s3_enable_cycles", 64'(ec), 64'd21);
    check("s3_timeout", {63'h0, to0}, 64'h1);
    check("s3_done", {63'h0, done0}, 64'h1);
    check("s3_vec", {61'h0, vec0}, 64'h0);
    check("s3_pass", {63'h0, pass0}, 64'h0);
    check("s3_enable_low", {63'h0, en0}, 64'h0);
    check("s3_seed0_timeout", {63'h0, to1}, 64'h1);

    // Scenario 4: reset during RUN of vector 1
    start = 1'b1; tick(); start = 1'b0;
    w = 0;
    while (!(vec0 == 3'd1 && en0) && w < 50) begin
      tick();
      w++;
    end
    check("s4_reached_v1", {63'h0, (vec0 == 3'd1 && en0)}, 64'h1);
    rst = 1'b1;
    tick();
    check("s4_rst_outputs", {mul_a0, 7'h0, en0, busy0, done0, pass0, to0, vec0, err0, 12'h0},
          64'h0);
    check("s4_rst_b", {32'h0, mul_b0}, 64'h0);
    check("s4_rst_sig", sig0, 64'h0);
    rst = 1'b0;
    tick();
    run(1'b0, n, ef, ec);
    check("s4_rerun_sig", sig0, exp1);
    check("s4_rerun_pass", {63'h0, pass0}, 64'h1);

    // Scenario 5: start pulses while busy are ignored
    run(1'b1, n, ef, ec);
    check("s5_cycles", 64'(n), 64'd22);
    check("s5_sig", sig0, exp1);
    check("s5_vec", {61'h0, vec0}, 64'd4);
    check("s5_pass", {63'h0, pass0}, 64'h1);
    check("s5_seed0_sig", sig1, exp1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
